// File: rtl/lc4_divider_seq_pkg.sv
// Shared constants for the LC4 sequential divider: FSM encoding and iteration count.
package lc4_divider_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    localparam int          DIV_ITERS    = 16;
    localparam logic [3:0]  DIV_LAST_CNT = 4'(DIV_ITERS - 1);

endpackage

// File: rtl/lc4_divider_one_iter.sv
// One restoring-division step: shift in the dividend MSB, subtract the divisor when it fits.
module lc4_divider_one_iter #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic [WIDTH-1:0] i_remainder,
    input  logic [WIDTH-1:0] i_quotient,
    output logic [WIDTH-1:0] o_dividend,
    output logic [WIDTH-1:0] o_remainder,
    output logic [WIDTH-1:0] o_quotient
);

    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    // The extra top bit keeps the shifted-out remainder bit in the compare.
    assign w_rem_sh = {i_remainder, i_dividend[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, i_divisor};
    assign w_fits   = (w_rem_sh >= {1'b0, i_divisor});

    assign o_dividend  = {i_dividend[WIDTH-2:0], 1'b0};
    assign o_remainder = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign o_quotient  = {i_quotient[WIDTH-2:0], w_fits};

endmodule

// File: rtl/lc4_divider_seq.sv
// Sequential LC4 divider: valid/ready accept, 16 restoring iterations, result held until ack.
module lc4_divider_seq
    import lc4_divider_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    input  logic             i_ack
);

    div_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_div, r_divisor, r_rem, r_quot;
    logic [WIDTH-1:0] r_q_out, r_r_out;
    logic [3:0]       r_count;
    logic             r_zero;

    logic [WIDTH-1:0] w_div_nxt, w_rem_nxt, w_quot_nxt;
    logic             w_last;

    lc4_divider_one_iter #(.WIDTH(WIDTH)) u_iter (
        .i_dividend  (r_div),
        .i_divisor   (r_divisor),
        .i_remainder (r_rem),
        .i_quotient  (r_quot),
        .o_dividend  (w_div_nxt),
        .o_remainder (w_rem_nxt),
        .o_quotient  (w_quot_nxt)
    );

    assign w_last = (r_count == DIV_LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: if (i_valid) w_state_nxt = DIV_BUSY;
            DIV_BUSY: if (w_last)  w_state_nxt = DIV_DONE;
            DIV_DONE: if (i_ack)   w_state_nxt = DIV_IDLE;
            default:               w_state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_count   <= '0;
            r_zero    <= 1'b0;
            r_q_out   <= '0;
            r_r_out   <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (i_valid) begin
                        r_div     <= i_dividend;
                        r_divisor <= i_divisor;
                        r_rem     <= '0;
                        r_quot    <= '0;
                        r_count   <= '0;
                        r_zero    <= (i_divisor == '0);
                    end
                end
                DIV_BUSY: begin
                    r_div   <= w_div_nxt;
                    r_rem   <= w_rem_nxt;
                    r_quot  <= w_quot_nxt;
                    r_count <= r_count + 4'd1;
                    // Result registers only move on the final step, so they hold through DONE and IDLE.
                    if (w_last) begin
                        r_q_out <= r_zero ? '0 : w_quot_nxt;
                        r_r_out <= r_zero ? '0 : w_rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready     = (r_state == DIV_IDLE);
    assign o_valid     = (r_state == DIV_DONE);
    assign o_quotient  = r_q_out;
    assign o_remainder = r_r_out;

endmodule

// File: tb/tb_lc4_divider_seq.sv
// Randomized self-checking bench for lc4_divider_seq against plain / and % arithmetic.
module tb_lc4_divider_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_dividend;
    logic [15:0] i_divisor;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_quotient;
    logic [15:0] o_remainder;
    logic        i_ack;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_res  = 0;

    always #5 clk = ~clk;

    lc4_divider_seq #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .i_ack       (i_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, wait for result, optional hold, then ack.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input bit noise, input int hold);
        int          k;
        bit          busy_ok;
        logic [15:0] eq, er;
        eq = (b == 16'd0) ? 16'd0 : a / b;
        er = (b == 16'd0) ? 16'd0 : a % b;

        k = 0;
        while (!o_ready && k < 40) begin
            tick();
            k++;
        end
        chk("ready_before_accept", {31'd0, o_ready}, 32'd1);

        i_valid = 1'b1; i_dividend = a; i_divisor = b;
        tick();
        n_acc++;
        i_valid = 1'b0;

        k = 0;
        busy_ok = 1'b1;
        while (k < 40) begin
            tick();
            k++;
            if (o_valid) break;
            if (o_ready) busy_ok = 1'b0;
            if (noise) begin
                i_valid    = 1'b1;
                i_dividend = 16'($urandom);
                i_divisor  = 16'($urandom);
                i_ack      = 1'($urandom);
            end
        end
        i_valid = 1'b0;
        i_ack   = 1'b0;

        chk("latency", k, 32'd16);
        chk("ready_low_in_busy", {31'd0, busy_ok}, 32'd1);
        chk("quotient", {16'd0, o_quotient}, {16'd0, eq});
        chk("remainder", {16'd0, o_remainder}, {16'd0, er});
        if (o_valid) n_res++;

        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", {31'd0, o_valid}, 32'd1);
            chk("hold_quotient", {16'd0, o_quotient}, {16'd0, eq});
            chk("hold_remainder", {16'd0, o_remainder}, {16'd0, er});
        end

        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        chk("valid_drop_after_ack", {31'd0, o_valid}, 32'd0);
        chk("ready_after_ack", {31'd0, o_ready}, 32'd1);
        chk("quotient_kept_after_ack", {16'd0, o_quotient}, {16'd0, eq});
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_ack = 1'b0;
        i_dividend = 16'd0; i_divisor = 16'd0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_quotient", {16'd0, o_quotient}, 32'd0);
        chk("reset_remainder", {16'd0, o_remainder}, 32'd0);

        run_op(16'd100, 16'd7, 1'b0, 0);
        run_op(16'hFFFF, 16'd1, 1'b0, 0);
        run_op(16'h0005, 16'hFFFF, 1'b0, 0);
        run_op(16'h1234, 16'd0, 1'b0, 0);
        run_op(16'd50000, 16'd123, 1'b1, 10);

        // Abort mid-operation.
        i_valid = 1'b1; i_dividend = 16'hABCD; i_divisor = 16'd3;
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        rst = 1'b1; i_valid = 1'b1; i_ack = 1'b1;
        tick();
        rst = 1'b0; i_valid = 1'b0; i_ack = 1'b0;
        chk("abort_ready", {31'd0, o_ready}, 32'd1);
        chk("abort_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_quotient", {16'd0, o_quotient}, 32'd0);
        chk("abort_remainder", {16'd0, o_remainder}, 32'd0);
        run_op(16'd9, 16'd3, 1'b0, 0);

        n_acc = 0;
        n_res = 0;
        for (int i = 0; i < 2000; i++)
            run_op(16'($urandom), 16'($urandom_range(1, 65535)), 1'b0, 0);
        for (int i = 0; i < 250; i++)
            run_op(16'($urandom), 16'($urandom_range(1, 15)), 1'b0, 0);
        for (int i = 0; i < 300; i++)
            run_op(16'($urandom), 16'd0, 1'b0, 0);
        chk("accepts_equal_results", n_res, n_acc);
        chk("accept_count", n_acc, 32'd2550);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
